// File: rtl/trace_pkg.sv
// Shared types and constants for the instruction trace buffer.
// Used by the capture side (trace_capture_buf) and the read/MMIO side.
// With TRACE_CAPTURE_TIMESTAMP_EN defined, each entry also carries a 32-bit cycle stamp.
package trace_pkg;

   localparam int TRACE_DEPTH    = 64;
   localparam int TRACE_PTR_BITS = 6;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      POST    = 2'd2,
      DONE    = 2'd3
   } trace_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
      logic [31:0] ts;
`endif
   } trace_entry_t;

   // True when a retired PC hits the armed trigger address
   function automatic logic trace_pc_match(input logic [31:0] pc, input logic [31:0] trig_pc);
      return (pc == trig_pc);
   endfunction

endpackage

// File: rtl/trace_ram_1w1r.sv
// Simple dual-port trace RAM: one write port and one registered read port.
// A read and a write of the same index in one cycle return the old contents.
// Storage is not reset; only the read data register clears on reset.
module trace_ram_1w1r
   import trace_pkg::*;
#(
   parameter int DEPTH    = TRACE_DEPTH,
   parameter int PTR_BITS = TRACE_PTR_BITS
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                we_i,
   input  logic [PTR_BITS-1:0] waddr_i,
   input  trace_entry_t        wdata_i,
   input  logic [PTR_BITS-1:0] raddr_i,
   output trace_entry_t        rdata_o
);

   trace_entry_t mem_r [DEPTH];
   trace_entry_t rdata_r;

   // Write port: store one entry per enabled cycle
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_r[waddr_i] <= wdata_i;
      end
   end

   // Read port: registered every cycle, sees pre-write contents
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata_r <= '0;
      end else begin
         rdata_r <= mem_r[raddr_i];
      end
   end

   assign rdata_o = rdata_r;

endmodule

// File: rtl/trace_capture_buf.sv
// Write side of the instruction trace buffer.
// Records {pc, instr} of each retired instruction into a circular RAM, with an
// optional PC-match trigger followed by POST_CNT more writes and then a freeze.
// Optional feature macro: TRACE_CAPTURE_TIMESTAMP_EN (per-entry cycle timestamp).
module trace_capture_buf
   import trace_pkg::*;
#(
   parameter int DEPTH        = 64,
   parameter int PTR_BITS     = 6,
   parameter int POST_CNT     = 16,
   parameter int ARM_ON_RESET = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                retire_valid_i,
   input  logic [31:0]         retire_pc_i,
   input  logic [31:0]         retire_instr_i,
   input  logic                arm_i,
   input  logic                trig_en_i,
   input  logic [31:0]         trig_pc_i,
   input  logic [PTR_BITS-1:0] rd_addr_i,
   output logic [31:0]         rd_pc_o,
   output logic [31:0]         rd_instr_o,
   output logic [31:0]         rd_ts_o,
   output logic [PTR_BITS-1:0] wr_ptr_o,
   output logic [PTR_BITS:0]   count_o,
   output logic                wrapped_o,
   output logic                triggered_o,
   output logic [PTR_BITS-1:0] trig_idx_o,
   output logic                frozen_o
);

   localparam trace_state_e        RESET_STATE = (ARM_ON_RESET != 0) ? CAPTURE : IDLE;
   localparam logic [PTR_BITS-1:0] POST_LOAD   = PTR_BITS'(POST_CNT);
   localparam logic [PTR_BITS-1:0] PTR_MAX     = PTR_BITS'(DEPTH - 1);
   localparam logic [PTR_BITS:0]   COUNT_FULL  = (PTR_BITS + 1)'(DEPTH);
   localparam logic                POST_IS_0   = (POST_CNT == 0);

   trace_state_e        state_r;
   trace_state_e        next_state_s;
   logic                wr_en_s;
   logic                trig_hit_s;
   logic                post_dec_s;
   logic [PTR_BITS-1:0] wr_ptr_r;
   logic [PTR_BITS:0]   count_r;
   logic                wrapped_r;
   logic                triggered_r;
   logic [PTR_BITS-1:0] trig_idx_r;
   logic [PTR_BITS-1:0] post_cnt_r;
   logic                frozen_r;
   trace_entry_t        wr_entry_s;
   trace_entry_t        rd_entry_s;

   // FSM state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r <= RESET_STATE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // FSM next state: arm restarts capture from any state and takes priority
   always_comb begin
      next_state_s = state_r;
      if (arm_i) begin
         next_state_s = CAPTURE;
      end else begin
         case (state_r)
            IDLE:    next_state_s = IDLE;
            CAPTURE: begin
               if (trig_hit_s) begin
                  next_state_s = POST_IS_0 ? DONE : POST;
               end else begin
                  next_state_s = CAPTURE;
               end
            end
            POST: begin
               if (post_dec_s && (post_cnt_r == PTR_BITS'(1))) begin
                  next_state_s = DONE;
               end else begin
                  next_state_s = POST;
               end
            end
            DONE:    next_state_s = DONE;
            default: next_state_s = RESET_STATE;
         endcase
      end
   end

   // FSM outputs: write enable, trigger detect, post-trigger countdown
   always_comb begin
      wr_en_s    = 1'b0;
      trig_hit_s = 1'b0;
      post_dec_s = 1'b0;
      case (state_r)
         CAPTURE: begin
            wr_en_s    = retire_valid_i && !arm_i;
            trig_hit_s = wr_en_s && trig_en_i && trace_pc_match(retire_pc_i, trig_pc_i);
         end
         POST: begin
            wr_en_s    = retire_valid_i && !arm_i;
            post_dec_s = wr_en_s;
         end
         default: begin
            wr_en_s    = 1'b0;
            trig_hit_s = 1'b0;
            post_dec_s = 1'b0;
         end
      endcase
   end

   // Pointer, fill count, wrap flag and trigger bookkeeping
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_r    <= '0;
         count_r     <= '0;
         wrapped_r   <= 1'b0;
         triggered_r <= 1'b0;
         trig_idx_r  <= '0;
         post_cnt_r  <= '0;
      end else if (arm_i) begin
         wr_ptr_r    <= '0;
         count_r     <= '0;
         wrapped_r   <= 1'b0;
         triggered_r <= 1'b0;
         trig_idx_r  <= '0;
         post_cnt_r  <= '0;
      end else begin
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + 1'b1;
            if (wr_ptr_r == PTR_MAX) begin
               wrapped_r <= 1'b1;
            end
            if (count_r != COUNT_FULL) begin
               count_r <= count_r + 1'b1;
            end
         end
         if (trig_hit_s) begin
            triggered_r <= 1'b1;
            trig_idx_r  <= wr_ptr_r;
            post_cnt_r  <= POST_LOAD;
         end else if (post_dec_s) begin
            post_cnt_r  <= post_cnt_r - 1'b1;
         end
      end
   end

   // Registered freeze flag, tracks entry into DONE
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         frozen_r <= 1'b0;
      end else begin
         frozen_r <= (next_state_s == DONE);
      end
   end

`ifdef TRACE_CAPTURE_TIMESTAMP_EN
   logic [31:0] ts_r;

   // Free-running cycle counter stamped into each entry
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ts_r <= 32'd0;
      end else begin
         ts_r <= ts_r + 32'd1;
      end
   end

   assign wr_entry_s = '{pc: retire_pc_i, instr: retire_instr_i, ts: ts_r};
   assign rd_ts_o    = rd_entry_s.ts;
`else
   assign wr_entry_s = '{pc: retire_pc_i, instr: retire_instr_i};
   assign rd_ts_o    = 32'd0;
`endif

   trace_ram_1w1r #(
      .DEPTH    (DEPTH),
      .PTR_BITS (PTR_BITS)
   ) u_ram (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (wr_en_s),
      .waddr_i (wr_ptr_r),
      .wdata_i (wr_entry_s),
      .raddr_i (rd_addr_i),
      .rdata_o (rd_entry_s)
   );

   assign rd_pc_o     = rd_entry_s.pc;
   assign rd_instr_o  = rd_entry_s.instr;
   assign wr_ptr_o    = wr_ptr_r;
   assign count_o     = count_r;
   assign wrapped_o   = wrapped_r;
   assign triggered_o = triggered_r;
   assign trig_idx_o  = trig_idx_r;
   assign frozen_o    = frozen_r;

endmodule

// File: tb/tb_trace_capture_buf.sv
// Self-checking bench for trace_capture_buf.
// Two instances share stimulus: index 0 with POST_CNT=16, index 1 with POST_CNT=0.
// A behavioural model of the trace buffer predicts every output each cycle.
module tb_trace_capture_buf;

   localparam int M_IDLE = 0;
   localparam int M_CAP  = 1;
   localparam int M_POST = 2;
   localparam int M_DONE = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        retire_valid;
   logic [31:0] retire_pc;
   logic [31:0] retire_instr;
   logic        arm;
   logic        trig_en;
   logic [31:0] trig_pc;
   logic [5:0]  rd_addr;

   logic [31:0] rd_pc     [2];
   logic [31:0] rd_instr  [2];
   logic [31:0] rd_ts     [2];
   logic [5:0]  wr_ptr    [2];
   logic [6:0]  count     [2];
   logic        wrapped   [2];
   logic        triggered [2];
   logic [5:0]  trig_idx  [2];
   logic        frozen    [2];

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_on   = 1'b0;

   // behavioural model state
   int unsigned m_pc  [2][64];
   int unsigned m_in  [2][64];
   int unsigned m_ts  [2][64];
   bit          m_val [2][64];
   int          m_mode [2];
   int          m_ptr  [2];
   int          m_cnt  [2];
   int          m_rem  [2];
   int          m_tidx [2];
   bit          m_wrap [2];
   bit          m_trig [2];
   int unsigned e_rd_pc [2];
   int unsigned e_rd_in [2];
   int unsigned e_rd_ts [2];
   bit          e_rd_val [2];
   int unsigned m_time;

   always #5 clk = ~clk;

   trace_capture_buf #(.DEPTH(64), .PTR_BITS(6), .POST_CNT(16), .ARM_ON_RESET(1)) dut_a (
      .clk_i(clk), .rst_i(rst), .retire_valid_i(retire_valid), .retire_pc_i(retire_pc),
      .retire_instr_i(retire_instr), .arm_i(arm), .trig_en_i(trig_en), .trig_pc_i(trig_pc),
      .rd_addr_i(rd_addr), .rd_pc_o(rd_pc[0]), .rd_instr_o(rd_instr[0]), .rd_ts_o(rd_ts[0]),
      .wr_ptr_o(wr_ptr[0]), .count_o(count[0]), .wrapped_o(wrapped[0]),
      .triggered_o(triggered[0]), .trig_idx_o(trig_idx[0]), .frozen_o(frozen[0]));

   trace_capture_buf #(.DEPTH(64), .PTR_BITS(6), .POST_CNT(0), .ARM_ON_RESET(1)) dut_b (
      .clk_i(clk), .rst_i(rst), .retire_valid_i(retire_valid), .retire_pc_i(retire_pc),
      .retire_instr_i(retire_instr), .arm_i(arm), .trig_en_i(trig_en), .trig_pc_i(trig_pc),
      .rd_addr_i(rd_addr), .rd_pc_o(rd_pc[1]), .rd_instr_o(rd_instr[1]), .rd_ts_o(rd_ts[1]),
      .wr_ptr_o(wr_ptr[1]), .count_o(count[1]), .wrapped_o(wrapped[1]),
      .triggered_o(triggered[1]), .trig_idx_o(trig_idx[1]), .frozen_o(frozen[1]));

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s[dut%0d] @%0t: got %h, expected %h", nm, k, $time, act, exp);
      end
   endtask

   function automatic int post_of(input int k);
      return (k == 0) ? 16 : 0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_mode[k] = M_CAP;
         m_ptr[k] = 0; m_cnt[k] = 0; m_rem[k] = 0; m_tidx[k] = 0;
         m_wrap[k] = 1'b0; m_trig[k] = 1'b0;
         e_rd_pc[k] = 0; e_rd_in[k] = 0; e_rd_ts[k] = 0; e_rd_val[k] = 1'b1;
      end
      m_time = 0;
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         e_rd_val[k] = m_val[k][rd_addr];
         e_rd_pc[k]  = m_pc[k][rd_addr];
         e_rd_in[k]  = m_in[k][rd_addr];
         e_rd_ts[k]  = m_ts[k][rd_addr];
         if (arm) begin
            m_mode[k] = M_CAP;
            m_ptr[k] = 0; m_cnt[k] = 0; m_tidx[k] = 0;
            m_wrap[k] = 1'b0; m_trig[k] = 1'b0;
         end else if (retire_valid && (m_mode[k] == M_CAP || m_mode[k] == M_POST)) begin
            m_val[k][m_ptr[k]] = 1'b1;
            m_pc[k][m_ptr[k]]  = retire_pc;
            m_in[k][m_ptr[k]]  = retire_instr;
            m_ts[k][m_ptr[k]]  = m_time;
            if (m_mode[k] == M_CAP && trig_en && retire_pc == trig_pc) begin
               m_trig[k] = 1'b1;
               m_tidx[k] = m_ptr[k];
               if (post_of(k) == 0) begin
                  m_mode[k] = M_DONE;
               end else begin
                  m_rem[k]  = post_of(k);
                  m_mode[k] = M_POST;
               end
            end else if (m_mode[k] == M_POST) begin
               m_rem[k]--;
               if (m_rem[k] == 0) m_mode[k] = M_DONE;
            end
            m_ptr[k] = (m_ptr[k] + 1) % 64;
            if (m_ptr[k] == 0) m_wrap[k] = 1'b1;
            if (m_cnt[k] < 64) m_cnt[k]++;
         end
      end
      m_time++;
   endtask

   // model update at each active clock edge or reset assertion
   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else model_step();
      end
   end

   // compare process: all outputs against the model on the falling edge
   initial begin
      forever begin
         @(negedge clk);
         if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
               chk("wr_ptr", k, 32'(wr_ptr[k]), 32'(m_ptr[k]));
               chk("count", k, 32'(count[k]), 32'(m_cnt[k]));
               chk("wrapped", k, 32'(wrapped[k]), 32'(m_wrap[k]));
               chk("triggered", k, 32'(triggered[k]), 32'(m_trig[k]));
               chk("trig_idx", k, 32'(trig_idx[k]), 32'(m_tidx[k]));
               chk("frozen", k, 32'(frozen[k]), 32'(m_mode[k] == M_DONE));
               if (e_rd_val[k]) begin
                  chk("rd_pc", k, rd_pc[k], e_rd_pc[k]);
                  chk("rd_instr", k, rd_instr[k], e_rd_in[k]);
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
                  chk("rd_ts", k, rd_ts[k], e_rd_ts[k]);
`else
                  chk("rd_ts", k, rd_ts[k], 32'd0);
`endif
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic retire(input logic [31:0] pc);
      retire_valid = 1'b1;
      retire_pc    = pc;
      retire_instr = $urandom;
      tick();
      retire_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; retire_valid = 1'b0; retire_pc = 32'd0; retire_instr = 32'd0;
      arm = 1'b0; trig_en = 1'b0; trig_pc = 32'd0; rd_addr = 6'd0;
      tick();
      chk_on = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      chk("reset_wr_ptr", 0, 32'(wr_ptr[0]), 32'd0);
      chk("reset_count", 0, 32'(count[0]), 32'd0);
      chk("reset_frozen", 0, 32'(frozen[0]), 32'd0);

      // fill exactly once: PCs 0x0..0xFC
      for (int i = 0; i < 64; i++) retire(32'(4 * i));
      chk("fill_wr_ptr", 0, 32'(wr_ptr[0]), 32'd0);
      chk("fill_wrapped", 0, 32'(wrapped[0]), 32'd1);
      chk("fill_count", 0, 32'(count[0]), 32'd64);
      for (int i = 0; i < 64; i++) begin
         rd_addr = 6'(i);
         tick();
         if (i == 0 || i == 17 || i == 63) chk("fill_rd_pc", 0, rd_pc[0], 32'(4 * i));
      end

      // six more retires overwrite the oldest entries
      for (int i = 64; i < 70; i++) retire(32'(4 * i));
      rd_addr = 6'd0;  tick(); chk("wrap_rd0", 0, rd_pc[0], 32'h100);
      rd_addr = 6'd5;  tick(); chk("wrap_rd5", 0, rd_pc[0], 32'h114);
      rd_addr = 6'd6;  tick(); chk("wrap_rd6", 0, rd_pc[0], 32'h18);
      chk("wrap_count", 0, 32'(count[0]), 32'd64);

      // trigger at PC 0x20 after re-arm
      arm = 1'b1; tick(); arm = 1'b0;
      trig_en = 1'b1; trig_pc = 32'h20;
      for (int i = 0; i < 40; i++) begin
         retire(32'(4 * i));
         if (i == 8) begin
            chk("trig_idx", 0, 32'(trig_idx[0]), 32'd8);
            chk("triggered", 0, 32'(triggered[0]), 32'd1);
            chk("post0_frozen", 1, 32'(frozen[1]), 32'd1);
         end
         if (i == 23) chk("frozen_early", 0, 32'(frozen[0]), 32'd0);
         if (i == 24) chk("frozen_at24", 0, 32'(frozen[0]), 32'd1);
      end
      chk("frozen_wr_ptr", 0, 32'(wr_ptr[0]), 32'd25);
      chk("post0_wr_ptr", 1, 32'(wr_ptr[1]), 32'd9);
      chk("post0_count", 1, 32'(count[1]), 32'd9);

      // arm with a same-cycle retire while frozen: that retire is dropped
      arm = 1'b1; retire(32'hDEAD_0000); arm = 1'b0; trig_en = 1'b0;
      chk("arm_wr_ptr", 0, 32'(wr_ptr[0]), 32'd0);
      chk("arm_triggered", 0, 32'(triggered[0]), 32'd0);
      for (int i = 0; i < 5; i++) retire(32'h1000 + 32'(4 * i));
      // read index 5 while it is written
      rd_addr = 6'd5;
      retire(32'h5555);
      chk("rbw_old", 0, rd_pc[0], 32'h14);
      tick();
      chk("rbw_new", 0, rd_pc[0], 32'h5555);
      rd_addr = 6'd0; tick();
      chk("arm_first_entry", 0, rd_pc[0], 32'h1000);

      // randomized traffic
      trig_pc = 32'h40;
      for (int c = 0; c < 3000; c++) begin
         retire_valid = ($urandom_range(0, 3) != 0);
         retire_pc    = 32'(4 * $urandom_range(0, 31));
         retire_instr = $urandom;
         trig_en      = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 99) == 0) trig_pc = 32'(4 * $urandom_range(0, 31));
         arm          = ($urandom_range(0, 49) == 0);
         rd_addr      = 6'($urandom_range(0, 63));
         rst          = ($urandom_range(0, 399) == 0);
         tick();
      end
      rst = 1'b0; arm = 1'b0; retire_valid = 1'b0;
      tick();
      tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
